// File: rtl/multi_dataflow_roberts_mdc_job_scheduler_pkg.sv
// Shared types and defaults for the roberts_mdc job scheduler.
//   job_desc_multi_dataflow_roberts_mdc_t   : one queued job (three base addresses + out_pel count)
//   state_sched_multi_dataflow_roberts_mdc_t: scheduler FSM states
//   MDC_SCHED_DEPTH / MDC_SCHED_TIMEOUT     : default FIFO depth and watchdog limit
package multi_dataflow_roberts_mdc_package;

  localparam int unsigned MDC_SCHED_DEPTH   = 4;
  localparam int unsigned MDC_SCHED_TIMEOUT = 65535;
  localparam int unsigned MDC_ADDR_W        = 32;
  localparam int unsigned MDC_CNT_W         = 16;

  typedef struct packed {
    logic [MDC_ADDR_W-1:0] in_pel_addr;
    logic [MDC_ADDR_W-1:0] in_size_addr;
    logic [MDC_ADDR_W-1:0] out_pel_addr;
    logic [MDC_CNT_W-1:0]  cnt_limit;
  } job_desc_multi_dataflow_roberts_mdc_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_READY = 2'd1,
    ST_RUN        = 2'd2,
    ST_DONE       = 2'd3
  } state_sched_multi_dataflow_roberts_mdc_t;

endpackage

// File: rtl/multi_dataflow_roberts_mdc_job_scheduler_job_fifo.sv
// Synchronous job-descriptor FIFO (flat DATA_W-bit entries).
// Ports: clk_i/rst_i (async active-high reset), flush_i (sync empty),
//        push_i/data_i (write, ignored when full), pop_i/data_o (head, ignored when empty),
//        full_o, empty_o, level_o (occupancy 0..DEPTH).
// DEPTH must be a power of two so the pointers wrap on their own.
module multi_dataflow_roberts_mdc_job_fifo #(
  parameter int unsigned DATA_W = 112,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [LVL_W-1:0]  level_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [LVL_W-1:0]  cnt_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (cnt_q == LVL_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Full refuses a push even when a pop frees a slot in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + LVL_W'(1);
        2'b01:   cnt_q <= cnt_q - LVL_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/multi_dataflow_roberts_mdc_job_scheduler.sv
// Job scheduler for the roberts_mdc HWPE: queues job descriptors and runs them one at a time.
// Ports:
//   clk_i, rst_i (async active-high), clear_i (sync soft clear, highest priority)
//   job_*      : descriptor input stream (job_valid_i / job_ready_o)
//   core_*     : active descriptor, start/abort pulses, ready/done from the HWPE FSM
//   busy_o, level_o, evt_o, jobs_done_o, err_o : status
//   dbg_state_o: current FSM state
// Handshake: a descriptor is taken on a cycle where job_valid_i and job_ready_o are both 1
// (and clear_i is 0); job_ready_o never depends on job_valid_i.
module multi_dataflow_roberts_mdc_job_scheduler
  import multi_dataflow_roberts_mdc_package::*;
#(
  parameter int unsigned DEPTH          = MDC_SCHED_DEPTH,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = MDC_SCHED_TIMEOUT,
  localparam int unsigned LVL_W         = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              job_valid_i,
  output logic              job_ready_o,
  input  logic [ADDR_W-1:0] job_in_pel_addr_i,
  input  logic [ADDR_W-1:0] job_in_size_addr_i,
  input  logic [ADDR_W-1:0] job_out_pel_addr_i,
  input  logic [CNT_W-1:0]  job_cnt_limit_i,
  input  logic              core_ready_i,
  output logic              core_start_o,
  output logic              core_abort_o,
  input  logic              core_done_i,
  output logic [ADDR_W-1:0] core_in_pel_addr_o,
  output logic [ADDR_W-1:0] core_in_size_addr_o,
  output logic [ADDR_W-1:0] core_out_pel_addr_o,
  output logic [CNT_W-1:0]  core_cnt_limit_o,
  output logic              busy_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              evt_o,
  output logic [CNT_W-1:0]  jobs_done_o,
  output logic              err_o,
  output logic [1:0]        dbg_state_o
);

  localparam int unsigned DESC_W  = 3 * ADDR_W + CNT_W;
  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_sched_multi_dataflow_roberts_mdc_t state_q, state_d;

  logic [DESC_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              rdy_en_q;
  logic              start_q, start_d;
  logic              abort_q, abort_d;
  logic              err_q, err_set;
  logic              done_inc;
  logic [CNT_W-1:0]  jobs_done_q;
  logic [31:0]       wd_q, wd_d;

  // Descriptor packing: {in_pel, in_size, out_pel, cnt_limit}, cnt_limit in the low bits.
  assign push = job_valid_i & job_ready_o & ~clear_i;

  multi_dataflow_roberts_mdc_job_fifo #(
    .DATA_W (DESC_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (clear_i),
    .push_i  (push),
    .data_i  ({job_in_pel_addr_i, job_in_size_addr_i, job_out_pel_addr_i, job_cnt_limit_i}),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  // Keeps job_ready_o low while reset is held and for the reset-release cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rdy_en_q <= 1'b0;
    else       rdy_en_q <= 1'b1;
  end

  assign job_ready_o = rdy_en_q & ~fifo_full;

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    start_d  = 1'b0;
    abort_d  = 1'b0;
    err_set  = 1'b0;
    done_inc = 1'b0;
    wd_d     = wd_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = (head[CNT_W-1:0] == '0) ? ST_DONE : ST_WAIT_READY;
        end
      end
      ST_WAIT_READY: begin
        if (core_ready_i) begin
          start_d = 1'b1;
          wd_d    = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        wd_d = wd_q + 32'd1;
        // Done takes precedence over a watchdog expiry in the same cycle.
        if (core_done_i) begin
          state_d = ST_DONE;
        end else if (WD_EN && (wd_q == WD_LAST)) begin
          abort_d = 1'b1;
          err_set = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        done_inc = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear_i) begin
      state_d  = ST_IDLE;
      pop      = 1'b0;
      start_d  = 1'b0;
      abort_d  = 1'b0;
      err_set  = 1'b0;
      done_inc = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q             <= ST_IDLE;
      start_q             <= 1'b0;
      abort_q             <= 1'b0;
      err_q               <= 1'b0;
      jobs_done_q         <= '0;
      wd_q                <= '0;
      core_in_pel_addr_o  <= '0;
      core_in_size_addr_o <= '0;
      core_out_pel_addr_o <= '0;
      core_cnt_limit_o    <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      abort_q <= abort_d;
      wd_q    <= wd_d;
      if (clear_i)       err_q <= 1'b0;
      else if (err_set)  err_q <= 1'b1;
      if (clear_i)       jobs_done_q <= '0;
      else if (done_inc) jobs_done_q <= jobs_done_q + CNT_W'(1);
      // The active descriptor is held until the next pop; clear does not touch it.
      if (pop) begin
        core_in_pel_addr_o  <= head[DESC_W-1 -: ADDR_W];
        core_in_size_addr_o <= head[DESC_W-ADDR_W-1 -: ADDR_W];
        core_out_pel_addr_o <= head[CNT_W +: ADDR_W];
        core_cnt_limit_o    <= head[CNT_W-1:0];
      end
    end
  end

  // Watchdog aborts come from a register; a clear aborts combinationally in its own cycle.
  assign core_abort_o = abort_q | (clear_i & ((state_q == ST_WAIT_READY) || (state_q == ST_RUN)));
  assign core_start_o = start_q;
  assign evt_o        = (state_q == ST_DONE);
  assign busy_o       = (state_q != ST_IDLE) | ~fifo_empty;
  assign jobs_done_o  = jobs_done_q;
  assign err_o        = err_q;
  assign dbg_state_o  = state_q;

endmodule
